// File: rtl/ps2_kb_matrix.sv
// ---------------------------------------------------------------------------
// ps2_kb_matrix
//   PS/2 keyboard front end for the Cobra1 core. Receives set-2 scancodes from
//   a PS/2 clock/data pair, decodes make/break events and maintains the
//   40-key switch matrix image consumed by the keyboard/tape decoder.
//   Runs entirely in the CPU clock domain.
//
// Parameters
//   FILTER_LEN   cycles the synced ps2_clk must hold a new level before the
//                filtered clock follows it
//   TIMEOUT_CYC  idle cycles allowed between frame bits before abort
//
// Ports
//   clk_cpu     in   core clock
//   rst_n       in   asynchronous active-low reset
//   ps2_clk     in   raw PS/2 clock (asynchronous)
//   ps2_dat     in   raw PS/2 data (asynchronous)
//   kb_state    out  [39:0] matrix image, bit row*5+col, 1 = key held
//   scan_code   out  [7:0]  last accepted byte
//   scan_valid  out  one-cycle pulse when scan_code is updated
//   frame_err   out  one-cycle pulse on bad start/stop/parity or timeout
//
// Configuration macro
//   PS2_PARITY_CHECK_EN  when defined, an odd-parity failure at the stop bit
//                        drops the byte and raises frame_err; otherwise the
//                        parity bit is consumed and ignored.
// ---------------------------------------------------------------------------
module ps2_kb_matrix #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 3250
) (
  input  logic        clk_cpu,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [39:0] kb_state,
  output logic [7:0]  scan_code,
  output logic        scan_valid,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  // Set-2 code -> {hit, row*5+col}
  function automatic logic [6:0] code_map(input logic [7:0] code);
    logic [6:0] r;
    r = 7'd0;
    case (code)
      8'h12: r = {1'b1, 6'd0};  8'h1A: r = {1'b1, 6'd1};  8'h22: r = {1'b1, 6'd2};
      8'h21: r = {1'b1, 6'd3};  8'h2A: r = {1'b1, 6'd4};
      8'h1C: r = {1'b1, 6'd5};  8'h1B: r = {1'b1, 6'd6};  8'h23: r = {1'b1, 6'd7};
      8'h2B: r = {1'b1, 6'd8};  8'h34: r = {1'b1, 6'd9};
      8'h15: r = {1'b1, 6'd10}; 8'h1D: r = {1'b1, 6'd11}; 8'h24: r = {1'b1, 6'd12};
      8'h2D: r = {1'b1, 6'd13}; 8'h2C: r = {1'b1, 6'd14};
      8'h16: r = {1'b1, 6'd15}; 8'h1E: r = {1'b1, 6'd16}; 8'h26: r = {1'b1, 6'd17};
      8'h25: r = {1'b1, 6'd18}; 8'h2E: r = {1'b1, 6'd19};
      8'h45: r = {1'b1, 6'd20}; 8'h46: r = {1'b1, 6'd21}; 8'h3E: r = {1'b1, 6'd22};
      8'h3D: r = {1'b1, 6'd23}; 8'h36: r = {1'b1, 6'd24};
      8'h4D: r = {1'b1, 6'd25}; 8'h44: r = {1'b1, 6'd26}; 8'h43: r = {1'b1, 6'd27};
      8'h3C: r = {1'b1, 6'd28}; 8'h35: r = {1'b1, 6'd29};
      8'h5A: r = {1'b1, 6'd30}; 8'h4B: r = {1'b1, 6'd31}; 8'h42: r = {1'b1, 6'd32};
      8'h3B: r = {1'b1, 6'd33}; 8'h33: r = {1'b1, 6'd34};
      8'h29: r = {1'b1, 6'd35}; 8'h59: r = {1'b1, 6'd36}; 8'h3A: r = {1'b1, 6'd37};
      8'h31: r = {1'b1, 6'd38}; 8'h32: r = {1'b1, 6'd39};
      default: r = 7'd0;
    endcase
    return r;
  endfunction

  // ---------------- input synchronisers and clock filter ----------------
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_f, clk_f_d;
  logic [FW-1:0] filt_cnt;
  logic          strobe;

  // NOTE: every register below uses non-blocking assignment so all flops
  // sample the pre-edge values; blocking here would collapse the
  // synchroniser stages into one.
  // Lines idle high, so the synchronisers and filter reset to 1 to avoid a
  // spurious falling edge right after reset.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_f    <= 1'b1;
      clk_f_d  <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      dat_s1  <= ps2_dat;
      dat_s2  <= dat_s1;
      clk_f_d <= clk_f;
      // Count consecutive samples that disagree with clk_f; follow after
      // FILTER_LEN of them, restart on any agreeing sample.
      if (clk_s2 == clk_f) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_f    <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign strobe = clk_f_d & ~clk_f;

  // ---------------- frame receiver and matrix decode ----------------
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [TW-1:0] to_cnt;
  logic          ext, brk;
  logic          parity_ok;
  logic [6:0]    map_r;

  assign map_r = code_map(shift);

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n)                        par_bit <= 1'b0;
    else if (strobe && state == PAR)   par_bit <= dat_s2;
  end
  assign parity_ok = ^{shift, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      to_cnt     <= '0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      kb_state   <= '0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE) begin
        to_cnt <= '0;
        if (strobe && !dat_s2) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
      end else if (strobe) begin
        to_cnt <= '0;
        case (state)
          DATA: begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PAR;
          end
          PAR:  state <= STOP;
          default: begin  // STOP
            state <= IDLE;
            if (dat_s2 && parity_ok) begin
              scan_code  <= shift;
              scan_valid <= 1'b1;
              case (shift)
                8'hE0: ext <= 1'b1;
                8'hF0: brk <= 1'b1;
                8'h00, 8'hFF: begin
                  kb_state <= '0;
                  ext      <= 1'b0;
                  brk      <= 1'b0;
                end
                default: begin
                  // Only unextended codes reach the matrix; prefixes and
                  // device replies (AA/FA/FE/EE) are unmapped and just
                  // clear the flags.
                  ext <= 1'b0;
                  brk <= 1'b0;
                  if (!ext && map_r[6]) kb_state[map_r[5:0]] <= ~brk;
                end
              endcase
            end else begin
              frame_err <= 1'b1;
            end
          end
        endcase
      end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
        frame_err <= 1'b1;
        state     <= IDLE;
        to_cnt    <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule
